instr_mem_pipe: RTL and testbench

- Parametrised, clocked instruction memory that replaces the hard-coded combinational program ROM used by the processor fetch stage.
- Holds DEPTH words of DATA_W bits and is byte-addressed by the PC.
- Serves fetch requests through a valid/ready handshake with configurable read latency.
- Supports in-system program loading, fetch flush on branch, and fault flagging for misaligned or out-of-range addresses.

---
 rtl/instr_mem_pipe.sv | 130 +++++++++++++
 tb/tb_instr_mem_pipe.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_pipe.sv
// instr_mem_pipe: clocked instruction memory for the fetch stage.
// Byte-addressed by PC, valid/ready fetch port, RD_LAT-deep read pipe.
// Ports:
//   clk, reset      : clock, async active-high reset
//   req_valid/ready : fetch handshake, req_addr = byte PC
//   rsp_valid/ready : response handshake
//   rsp_instr/addr  : fetched word and the PC that produced it
//   rsp_fault       : bit0 misaligned, bit1 out of range
//   flush           : drop all in-flight responses
//   ld_en/addr/data : program-load write port
//   ld_err          : one-cycle pulse when a load is dropped
module instr_mem_pipe #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64,
  parameter int RD_LAT = 1,
  parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_instr,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic [1:0]        rsp_fault,
  input  logic              flush,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_err
);

  localparam int BYTES = DATA_W / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int HI    = OFF_W + IDX_W;
  localparam logic [ADDR_W-1:0] OFF_MASK =
    ADDR_W'(BYTES - 1);

  typedef struct packed {
    logic              v;
    logic [ADDR_W-1:0] a;
    logic [1:0]        f;
    logic [DATA_W-1:0] d;
  } stage_t;

  // bit0: low offset bits set; bit1: any bit
  // above the word index set (no aliasing)
  function automatic logic [1:0] addr_flt(
    input logic [ADDR_W-1:0] a
  );
    logic [1:0] r;
    r[0] = (a & OFF_MASK) != '0;
    r[1] = (a >> HI) != '0;
    return r;
  endfunction

  logic [DATA_W-1:0] mem [DEPTH];

  stage_t            st_q [RD_LAT];
  stage_t            st_in;
  logic [1:0]        req_flt;
  logic [1:0]        ld_flt;
  logic [IDX_W-1:0]  req_idx;
  logic [IDX_W-1:0]  ld_idx;
  logic [DATA_W-1:0] rd_word;
  logic              stall;
  logic              accept;
  logic              ld_err_q;

  assign req_flt = addr_flt(req_addr);
  assign ld_flt  = addr_flt(ld_addr);
  assign req_idx = req_addr[OFF_W +: IDX_W];
  assign ld_idx  = ld_addr[OFF_W +: IDX_W];

  assign rsp_valid = st_q[RD_LAT-1].v;
  assign rsp_addr  = st_q[RD_LAT-1].a;
  assign rsp_fault = st_q[RD_LAT-1].f;
  assign rsp_instr = st_q[RD_LAT-1].d;
  assign ld_err    = ld_err_q;

  assign stall     = rsp_valid && !rsp_ready;
  assign req_ready = !ld_en && !stall;
  assign accept    = req_valid && req_ready;

  // faulted fetches never touch the array
  assign rd_word = (req_flt != 2'b00)
                 ? NOP_WORD : mem[req_idx];

  always_comb begin
    st_in   = '0;
    st_in.v = accept;
    st_in.a = req_addr;
    st_in.f = req_flt;
    st_in.d = rd_word;
  end

  // contents survive reset by design
  always_ff @(posedge clk) begin
    if (ld_en && ld_flt == 2'b00)
      mem[ld_idx] <= ld_data;
  end

  // a request accepted alongside flush
  // enters stage 0 and survives
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < RD_LAT; i++)
        st_q[i] <= '0;
    end else if (!stall) begin
      st_q[0] <= st_in;
      for (int i = 1; i < RD_LAT; i++) begin
        st_q[i] <= st_q[i-1];
        if (flush) st_q[i].v <= 1'b0;
      end
    end else if (flush) begin
      for (int i = 0; i < RD_LAT; i++)
        st_q[i].v <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ld_err_q <= 1'b0;
    else       ld_err_q <= ld_en && (ld_flt != 2'b00);
  end

endmodule

// File: tb/tb_instr_mem_pipe.sv
// tb_instr_mem_pipe: directed + random bench for instr_mem_pipe.
// Reference: word array plus ordered queue of expected responses.
module tb_instr_mem_pipe;

  localparam int DEPTH  = 64;
  localparam int RD_LAT = 2;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_instr;
  logic [31:0] rsp_addr;
  logic [1:0]  rsp_fault;
  logic        flush;
  logic        ld_en;
  logic [31:0] ld_addr;
  logic [31:0] ld_data;
  logic        ld_err;

  instr_mem_pipe #(
    .ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH),
    .RD_LAT(RD_LAT), .NOP_WORD(NOP)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_instr(rsp_instr), .rsp_addr(rsp_addr),
    .rsp_fault(rsp_fault), .flush(flush),
    .ld_en(ld_en), .ld_addr(ld_addr),
    .ld_data(ld_data), .ld_err(ld_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [1:0]  f;
    int          c;
  } exp_t;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  logic [31:0] mm [DEPTH];
  exp_t        exp_q [$];
  logic        exp_le = 1'b0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_i, prev_a;
  logic        obs_v, obs_rdy, obs_le;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] mflt(
    input logic [31:0] a
  );
    logic oor, mis;
    oor = a >= 32'(DEPTH * 4);
    mis = (a % 4) != 0;
    return {oor, mis};
  endfunction

  function automatic logic [31:0] raddr();
    int k;
    k = int'($urandom % 16);
    if (k == 0)
      return 32'(($urandom % DEPTH) * 4
                 + 1 + $urandom % 3);
    if (k == 1)
      return 32'(DEPTH * 4 + ($urandom % 64) * 4);
    if (k == 2)
      return 32'hFFFF_FFFC;
    return 32'(($urandom % DEPTH) * 4);
  endfunction

  // one clock: sample at negedge, update model,
  // return 1 time unit after the rising edge
  task automatic step();
    exp_t e;
    @(negedge clk);
    obs_v   = rsp_valid;
    obs_rdy = req_ready;
    obs_le  = ld_err;
    chk("req_ready", req_ready,
        !ld_en && !(rsp_valid && !rsp_ready));
    chk("ld_err", ld_err, exp_le);
    if (prev_stall) begin
      chk("hold_v", rsp_valid, 1);
      chk("hold_instr", rsp_instr, prev_i);
      chk("hold_addr", rsp_addr, prev_a);
    end
    if (rsp_valid && rsp_ready) begin
      chk("rsp_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("rsp_addr", rsp_addr, e.a);
        chk("rsp_instr", rsp_instr, e.d);
        chk("rsp_fault", rsp_fault, e.f);
        chk("rsp_latency", cyc >= e.c + RD_LAT, 1);
      end
    end
    if (flush) exp_q.delete();
    if (req_valid && req_ready) begin
      e.a = req_addr;
      e.f = mflt(req_addr);
      e.d = (e.f != 0) ? NOP : mm[req_addr / 4];
      e.c = cyc;
      exp_q.push_back(e);
    end
    exp_le = ld_en && (mflt(ld_addr) != 0);
    if (ld_en && mflt(ld_addr) == 0)
      mm[ld_addr / 4] = ld_data;
    prev_stall = rsp_valid && !rsp_ready && !flush;
    prev_i = rsp_instr;
    prev_a = rsp_addr;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle();
    req_valid = 0; flush = 0; ld_en = 0;
    rsp_ready = 1;
  endtask

  initial begin
    logic [31:0] plan_w [5];
    plan_w[0] = 32'h5800000F;
    plan_w[1] = 32'h58080010;
    plan_w[2] = 32'h58180012;
    plan_w[3] = 32'h10009000;
    plan_w[4] = 32'h08000002;

    reset = 1; req_valid = 0; req_addr = 0;
    rsp_ready = 1; flush = 0; ld_en = 0;
    ld_addr = 0; ld_data = 0;
    @(negedge clk);
    chk("rst_valid", rsp_valid, 0);
    chk("rst_instr", rsp_instr, 0);
    chk("rst_addr", rsp_addr, 0);
    chk("rst_fault", rsp_fault, 0);
    chk("rst_ld_err", ld_err, 0);
    reset = 0;
    @(posedge clk);
    #1;
    chk("rdy_after_rst", req_ready, 1);

    // preload every word so fetches are defined
    for (int i = 0; i < DEPTH; i++) begin
      idle();
      ld_en = 1; ld_addr = 32'(i * 4);
      ld_data = $urandom;
      step();
    end
    for (int i = 0; i < 5; i++) begin
      idle();
      ld_en = 1; ld_addr = 32'(i * 4);
      ld_data = plan_w[i];
      step();
    end

    // back-to-back fetch, exact latency
    for (int i = 0; i < 8; i++) begin
      idle();
      req_valid = (i < 5);
      req_addr = 32'(i * 4);
      step();
      chk("b2b_valid", obs_v, (i >= 2 && i <= 6));
    end
    chk("plan_word3", mm[3], 32'h10009000);

    // faults: misaligned, then out of range
    idle(); req_valid = 1; req_addr = 6; step();
    idle(); req_valid = 1;
    req_addr = 32'(DEPTH * 4); step();
    for (int i = 0; i < 3; i++) begin
      idle(); step();
    end

    // stall with a request held
    idle(); req_valid = 1; req_addr = 8; step();
    for (int i = 0; i < 5; i++) begin
      idle(); rsp_ready = 0;
      req_valid = 1; req_addr = 12;
      step();
      if (i >= 1) chk("stall_rdy", obs_rdy, 0);
    end
    for (int i = 0; i < 4; i++) begin
      idle(); step();
    end

    // flush with a branch-target request
    for (int i = 0; i < 3; i++) begin
      idle(); req_valid = 1;
      req_addr = 32'(i * 4); step();
    end
    idle(); flush = 1; req_valid = 1;
    req_addr = 12; step();
    idle(); step();
    chk("flush_v", obs_v, 0);
    for (int i = 0; i < 3; i++) begin
      idle(); step();
    end

    // load beats fetch; read-after-write
    idle(); ld_en = 1; ld_addr = 4;
    ld_data = 32'hCAFE_0004;
    req_valid = 1; req_addr = 4; step();
    chk("ld_blocks_req", obs_rdy, 0);
    idle(); req_valid = 1; req_addr = 4; step();
    idle(); ld_en = 1; ld_addr = 2;
    ld_data = 32'hDEAD_BEEF; step();
    idle(); step();
    chk("ld_err_pulse", obs_le, 1);
    idle(); req_valid = 1; req_addr = 0; step();
    chk("ld_err_clear", obs_le, 0);
    for (int i = 0; i < 3; i++) begin
      idle(); step();
    end

    // async reset mid-burst
    for (int i = 0; i < 3; i++) begin
      idle(); req_valid = 1;
      req_addr = 32'(i * 4 + 4); step();
    end
    idle();
    chk("pre_rst_v", rsp_valid, 1);
    #2 reset = 1;
    #1 chk("async_rst_v", rsp_valid, 0);
    exp_q.delete();
    prev_stall = 0; exp_le = 0;
    @(negedge clk);
    chk("rst2_valid", rsp_valid, 0);
    chk("rst2_addr", rsp_addr, 0);
    chk("rst2_instr", rsp_instr, 0);
    reset = 0;
    @(posedge clk);
    #1;
    cyc++;
    idle(); req_valid = 1; req_addr = 16; step();
    idle(); req_valid = 1; req_addr = 4; step();
    for (int i = 0; i < 3; i++) begin
      idle(); step();
    end

    // random traffic
    for (int i = 0; i < 500; i++) begin
      req_valid = ($urandom % 4) != 0;
      req_addr  = raddr();
      rsp_ready = ($urandom % 4) != 0;
      flush     = ($urandom % 20) == 0;
      ld_en     = ($urandom % 12) == 0;
      ld_addr   = raddr();
      ld_data   = $urandom;
      step();
    end

    // bounded drain
    for (int i = 0; i < 20; i++) begin
      idle();
      if (exp_q.size() != 0 || rsp_valid) step();
    end
    chk("drain_empty", exp_q.size(), 0);
    chk("drain_valid", rsp_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
